// File: rtl/ifq.sv
// Instruction fetch queue: circular FIFO of {pc, ins} pairs between fetch and decode.
// Latency: 1 cycle from push to head (0 cycles through the empty-queue bypass when IFQ_BYPASS_EN is defined).
// Backpressure: o_pre_ready drops when full or flushing, independent of i_post_ready; decode stalls hold the head.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef INS_WIDTH
`define INS_WIDTH 32
`endif

module ifq #(
    parameter int DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_flush,
    input  logic                    i_pre_valid,
    output logic                    o_pre_ready,
    input  logic [`CPU_WIDTH-1:0]   i_ifu_pc,
    input  logic [`INS_WIDTH-1:0]   i_ifu_ins,
    output logic                    o_post_valid,
    input  logic                    i_post_ready,
    output logic [`CPU_WIDTH-1:0]   o_ifq_pc,
    output logic [`INS_WIDTH-1:0]   o_ifq_ins,
    output logic [$clog2(DEPTH):0]  o_ifq_cnt
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);

    logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [`CPU_WIDTH-1:0] pc_mem_q  [DEPTH];
    logic [`CPU_WIDTH-1:0] pc_mem_d  [DEPTH];
    logic [`INS_WIDTH-1:0] ins_mem_q [DEPTH];
    logic [`INS_WIDTH-1:0] ins_mem_d [DEPTH];

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             bypass_hit;
    logic             wr_en;
    logic             rd_en;

    assign wr_idx = wr_ptr_q[IDX_W-1:0];
    assign rd_idx = rd_ptr_q[IDX_W-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[CNT_W-1] != rd_ptr_q[CNT_W-1]);

    assign o_pre_ready = !full && !i_flush;
    assign push        = i_pre_valid && o_pre_ready;
    assign pop         = o_post_valid && i_post_ready;

`ifdef IFQ_BYPASS_EN
    // An empty queue hands the incoming entry straight to decode; it is only stored if decode stalls.
    assign bypass_hit   = empty && i_pre_valid && !i_flush;
    assign o_post_valid = (!empty || bypass_hit) && !i_flush;
    assign o_ifq_pc     = bypass_hit ? i_ifu_pc  : pc_mem_q[rd_idx];
    assign o_ifq_ins    = bypass_hit ? i_ifu_ins : ins_mem_q[rd_idx];
    assign wr_en        = push && !(bypass_hit && i_post_ready);
    assign rd_en        = pop && !empty;
`else
    assign bypass_hit   = 1'b0;
    assign o_post_valid = !empty && !i_flush;
    assign o_ifq_pc     = pc_mem_q[rd_idx];
    assign o_ifq_ins    = ins_mem_q[rd_idx];
    assign wr_en        = push;
    assign rd_en        = pop;
`endif

    assign o_ifq_cnt = wr_ptr_q - rd_ptr_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pc_mem_d  = pc_mem_q;
        ins_mem_d = ins_mem_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) begin
                pc_mem_d[wr_idx]  = i_ifu_pc;
                ins_mem_d[wr_idx] = i_ifu_ins;
                wr_ptr_d          = wr_ptr_q + CNT_W'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]  <= '0;
                ins_mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pc_mem_q  <= pc_mem_d;
            ins_mem_q <= ins_mem_d;
        end
    end

    // Handshake gating makes these unreachable; they guard against future edits to ready/valid.
    a_no_overflow:  assert property (@(posedge i_clk) disable iff (!i_rst_n) !(wr_en && full));
    a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(rd_en && empty));

endmodule

// File: tb/tb_ifq.sv
// Directed bench for ifq: reset, single entry, fill/drain, streaming wrap, flush, async reset.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef INS_WIDTH
`define INS_WIDTH 32
`endif

module tb_ifq;

    logic                  clk;
    logic                  rst_n;
    logic                  flush;
    logic                  pre_valid;
    logic                  pre_ready;
    logic [`CPU_WIDTH-1:0] ifu_pc;
    logic [`INS_WIDTH-1:0] ifu_ins;
    logic                  post_valid;
    logic                  post_ready;
    logic [`CPU_WIDTH-1:0] ifq_pc;
    logic [`INS_WIDTH-1:0] ifq_ins;
    logic [2:0]            ifq_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    ifq #(.DEPTH(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_flush      (flush),
        .i_pre_valid  (pre_valid),
        .o_pre_ready  (pre_ready),
        .i_ifu_pc     (ifu_pc),
        .i_ifu_ins    (ifu_ins),
        .o_post_valid (post_valid),
        .i_post_ready (post_ready),
        .o_ifq_pc     (ifq_pc),
        .o_ifq_ins    (ifq_ins),
        .o_ifq_cnt    (ifq_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; pre_valid = 1'b0; post_ready = 1'b0;
        ifu_pc = '0; ifu_ins = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (post_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", post_valid); end
        n_cmp++; if (pre_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", pre_ready); end
        n_cmp++; if (ifq_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", ifq_cnt); end
        n_cmp++; if (ifq_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", ifq_pc); end
        n_cmp++; if (ifq_ins !== 32'h0) begin n_fail++; $display("FAIL reset_ins got=%h exp=0", ifq_ins); end
        tick();
    endtask

    task automatic test_single();
        pre_valid = 1'b1; ifu_pc = 32'h8000_0000; ifu_ins = 32'h0000_0013; post_ready = 1'b1;
        @(negedge clk);
`ifdef IFQ_BYPASS_EN
        n_cmp++; if (post_valid !== 1'b1) begin n_fail++; $display("FAIL single_bypass_valid got=%b exp=1", post_valid); end
        n_cmp++; if (ifq_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL single_bypass_pc got=%h exp=80000000", ifq_pc); end
        tick();
        pre_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (ifq_cnt !== 3'd0) begin n_fail++; $display("FAIL single_bypass_cnt got=%0d exp=0", ifq_cnt); end
        n_cmp++; if (post_valid !== 1'b0) begin n_fail++; $display("FAIL single_bypass_after got=%b exp=0", post_valid); end
        tick();
`else
        n_cmp++; if (post_valid !== 1'b0) begin n_fail++; $display("FAIL single_n_valid got=%b exp=0", post_valid); end
        tick();
        pre_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (post_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", post_valid); end
        n_cmp++; if (ifq_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL single_pc got=%h exp=80000000", ifq_pc); end
        n_cmp++; if (ifq_ins !== 32'h0000_0013) begin n_fail++; $display("FAIL single_ins got=%h exp=00000013", ifq_ins); end
        n_cmp++; if (ifq_cnt !== 3'd1) begin n_fail++; $display("FAIL single_cnt1 got=%0d exp=1", ifq_cnt); end
        tick();
        @(negedge clk);
        n_cmp++; if (ifq_cnt !== 3'd0) begin n_fail++; $display("FAIL single_cnt2 got=%0d exp=0", ifq_cnt); end
        n_cmp++; if (post_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty got=%b exp=0", post_valid); end
        tick();
`endif
    endtask

    task automatic test_fill_drain();
        post_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pre_valid = 1'b1; ifu_pc = 32'h8000_0000 + 32'(4 * i); ifu_ins = 32'h100 + 32'(i);
            @(negedge clk);
            n_cmp++; if (pre_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, pre_ready); end
            tick();
        end
        // Offer a fifth entry while full: it must be refused.
        pre_valid = 1'b1; ifu_pc = 32'hDEAD_BEEF; ifu_ins = 32'hDEAD_BEEF;
        @(negedge clk);
        n_cmp++; if (ifq_cnt !== 3'd4) begin n_fail++; $display("FAIL full_cnt got=%0d exp=4", ifq_cnt); end
        n_cmp++; if (pre_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", pre_ready); end
        n_cmp++; if (ifq_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL full_head got=%h exp=80000000", ifq_pc); end
        tick();
        pre_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (ifq_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL hold_head got=%h exp=80000000", ifq_pc); end
        n_cmp++; if (ifq_cnt !== 3'd4) begin n_fail++; $display("FAIL hold_cnt got=%0d exp=4", ifq_cnt); end
        tick();
        post_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (post_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, post_valid); end
            n_cmp++; if (ifq_pc !== 32'h8000_0000 + 32'(4 * i)) begin n_fail++; $display("FAIL drain_pc[%0d] got=%h exp=%h", i, ifq_pc, 32'h8000_0000 + 32'(4 * i)); end
            n_cmp++; if (ifq_ins !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL drain_ins[%0d] got=%h exp=%h", i, ifq_ins, 32'h100 + 32'(i)); end
            n_cmp++; if (pre_ready !== (i != 0)) begin n_fail++; $display("FAIL drain_ready[%0d] got=%b exp=%b", i, pre_ready, (i != 0)); end
            tick();
        end
        @(negedge clk);
        n_cmp++; if (post_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%b exp=0", post_valid); end
        n_cmp++; if (ifq_cnt !== 3'd0) begin n_fail++; $display("FAIL drain_cnt got=%0d exp=0", ifq_cnt); end
        tick();
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int popped = 0;
        post_ready = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            pre_valid = (sent < 10);
            ifu_pc    = 32'h0000_1000 + 32'(4 * sent);
            ifu_ins   = 32'hA000 + 32'(sent);
            @(negedge clk);
            if (post_valid === 1'b1) begin
                n_cmp++;
                if (ifq_pc !== 32'h0000_1000 + 32'(4 * popped)) begin
                    n_fail++; $display("FAIL stream_pc[%0d] got=%h exp=%h", popped, ifq_pc, 32'h0000_1000 + 32'(4 * popped));
                end
                popped++;
            end
            if (pre_valid && pre_ready) sent++;
            tick();
        end
        pre_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (popped !== 10) begin n_fail++; $display("FAIL stream_count got=%0d exp=10", popped); end
        n_cmp++; if (ifq_cnt !== 3'd0) begin n_fail++; $display("FAIL stream_cnt got=%0d exp=0", ifq_cnt); end
        tick();
    endtask

    task automatic test_flush();
        post_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pre_valid = 1'b1; ifu_pc = 32'h0000_A000 + 32'(4 * i); ifu_ins = 32'h1;
            tick();
        end
        pre_valid = 1'b1; ifu_pc = 32'h0000_0BAD; ifu_ins = 32'h0000_0BAD; flush = 1'b1;
        @(negedge clk);
        n_cmp++; if (post_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", post_valid); end
        n_cmp++; if (pre_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got=%b exp=0", pre_ready); end
        n_cmp++; if (ifq_cnt !== 3'd3) begin n_fail++; $display("FAIL flush_precnt got=%0d exp=3", ifq_cnt); end
        tick();
        flush = 1'b0; pre_valid = 1'b0; post_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (ifq_cnt !== 3'd0) begin n_fail++; $display("FAIL flush_cnt got=%0d exp=0", ifq_cnt); end
        n_cmp++; if (post_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after_valid got=%b exp=0", post_valid); end
        n_cmp++; if (pre_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after_ready got=%b exp=1", pre_ready); end
        tick();
        @(negedge clk);
        n_cmp++; if (post_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak got=%b pc=%h exp=0", post_valid, ifq_pc); end
        tick();
    endtask

    task automatic test_async_reset();
        post_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pre_valid = 1'b1; ifu_pc = 32'h0000_C000 + 32'(4 * (i + 1)); ifu_ins = 32'h77;
            tick();
        end
        pre_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (ifq_cnt !== 3'd2) begin n_fail++; $display("FAIL ares_precnt got=%0d exp=2", ifq_cnt); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (post_valid !== 1'b0) begin n_fail++; $display("FAIL ares_valid got=%b exp=0", post_valid); end
        n_cmp++; if (pre_ready !== 1'b1) begin n_fail++; $display("FAIL ares_ready got=%b exp=1", pre_ready); end
        n_cmp++; if (ifq_cnt !== 3'd0) begin n_fail++; $display("FAIL ares_cnt got=%0d exp=0", ifq_cnt); end
        n_cmp++; if (ifq_pc !== 32'h0) begin n_fail++; $display("FAIL ares_pc got=%h exp=0", ifq_pc); end
        n_cmp++; if (ifq_ins !== 32'h0) begin n_fail++; $display("FAIL ares_ins got=%h exp=0", ifq_ins); end
        tick();
        rst_n = 1'b1;
        post_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (ifq_cnt !== 3'd0) begin n_fail++; $display("FAIL ares_after_cnt got=%0d exp=0", ifq_cnt); end
        n_cmp++; if (post_valid !== 1'b0) begin n_fail++; $display("FAIL ares_after_valid got=%b exp=0", post_valid); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
